vend_dispenser: RTL

Dispense-and-change responder behind the vending-machine control FSM. The FSM issues one vend transaction: product, quantity, unit price and amount paid. This block computes the total, pulses the selected product motor once per item, then pays change as a greedy sequence of 10/5/1 coin pulses and reports completion. It sits between the control FSM and the motor/coin-hopper driver pins.

---
 rtl/vend_pkg.sv | 71 +++++++
 rtl/pulse_timer.sv | 76 +++++++
 rtl/vend_dispenser.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vend dispenser slice.
//
// Contents:
//   - field widths for product code, quantity, price/amount and total
//   - valid product code range (1..5) and coin denominations (10, 5, 1)
//   - dispenser FSM state enum, pulse timer phase enum, coin selector enum
//   - pick_coin / coin_value helpers for greedy change
package vend_pkg;

    localparam int PROD_W       = 3;
    localparam int QTY_W        = 4;
    localparam int PRICE_W      = 8;
    localparam int AMOUNT_W     = 8;
    localparam int TOTAL_W      = 12;
    localparam int NUM_PRODUCTS = 5;

    localparam logic [PROD_W-1:0] PRODUCT_MIN = 3'd1;
    localparam logic [PROD_W-1:0] PRODUCT_MAX = 3'd5;

    localparam logic [AMOUNT_W-1:0] COIN_VAL_10 = 8'd10;
    localparam logic [AMOUNT_W-1:0] COIN_VAL_5  = 8'd5;
    localparam logic [AMOUNT_W-1:0] COIN_VAL_1  = 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        DISPENSE,
        D_GAP,
        CHANGE,
        C_GAP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_HIGH,
        T_LOW
    } timer_phase_e;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_10,
        COIN_5,
        COIN_1
    } coin_e;

    // Largest coin that does not exceed the remaining change.
    function automatic coin_e pick_coin(input logic [AMOUNT_W-1:0] remaining);
        coin_e c;
        if (remaining >= COIN_VAL_10) begin
            c = COIN_10;
        end else if (remaining >= COIN_VAL_5) begin
            c = COIN_5;
        end else begin
            c = COIN_1;
        end
        return c;
    endfunction

    function automatic logic [AMOUNT_W-1:0] coin_value(input coin_e c);
        logic [AMOUNT_W-1:0] v;
        case (c)
            COIN_10: v = COIN_VAL_10;
            COIN_5:  v = COIN_VAL_5;
            COIN_1:  v = COIN_VAL_1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Pulse/gap sequencer shared by the motor and coin phases.
//
// A start strobe begins a high phase of high_len cycles followed by a low
// phase of low_len cycles (both >= 1). A start while a sequence is running
// restarts it.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        begin a new pulse; the high phase starts the next cycle
//   high_len     high phase length in cycles
//   low_len      low (gap) phase length in cycles
//   pulse_done   high during the last cycle of the high phase
//   gap_done     high during the last cycle of the low phase
module pulse_timer
    import vend_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] low_len,
    output logic          pulse_done,
    output logic          gap_done
);

    timer_phase_e  phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter holds "cycles left minus one" so it reaches zero on the
    // final cycle of each phase, which is when the owner must decide.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (start) begin
            phase_d = T_HIGH;
            cnt_d   = high_len - CW'(1);
        end else begin
            case (phase_q)
                T_HIGH: begin
                    if (cnt_q == '0) begin
                        phase_d = T_LOW;
                        cnt_d   = low_len - CW'(1);
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                T_LOW: begin
                    if (cnt_q == '0) begin
                        phase_d = T_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    phase_d = T_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= T_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse_done = (phase_q == T_HIGH) && (cnt_q == '0);
    assign gap_done   = (phase_q == T_LOW)  && (cnt_q == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Dispense-and-change responder behind the vending control FSM.
//
// Accepts one vend transaction, computes the total, pulses the selected
// product motor once per item, pays change as greedy 10/5/1 coin pulses and
// signals completion with a one-cycle done (plus error if refused).
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   vend_valid / vend_ready    request handshake; ready only in IDLE
//   product, quantity          product code (1..5), item count (0 = refund)
//   unit_price, paid           whole-dollar price per item and amount paid
//   motor                      one-hot motor drive, bit product-1
//   coin_10, coin_5, coin_1    coin hopper pulses
//   busy                       high whenever not IDLE
//   done, error                one-cycle completion pulse / refusal flag
//   change_out                 change computed for the current transaction
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int MOTOR_PULSE_CYCLES = 4,
    parameter int COIN_PULSE_CYCLES  = 2,
    parameter int GAP_CYCLES         = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vend_valid,
    output logic                    vend_ready,
    input  logic [PROD_W-1:0]       product,
    input  logic [QTY_W-1:0]        quantity,
    input  logic [PRICE_W-1:0]      unit_price,
    input  logic [AMOUNT_W-1:0]     paid,
    output logic [NUM_PRODUCTS-1:0] motor,
    output logic                    coin_10,
    output logic                    coin_5,
    output logic                    coin_1,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [AMOUNT_W-1:0]     change_out
);

    localparam int CNT_MAX =
        (MOTOR_PULSE_CYCLES > COIN_PULSE_CYCLES)
            ? ((MOTOR_PULSE_CYCLES > GAP_CYCLES) ? MOTOR_PULSE_CYCLES : GAP_CYCLES)
            : ((COIN_PULSE_CYCLES > GAP_CYCLES) ? COIN_PULSE_CYCLES : GAP_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] MOTOR_LEN = CW'(MOTOR_PULSE_CYCLES);
    localparam logic [CW-1:0] COIN_LEN  = CW'(COIN_PULSE_CYCLES);
    localparam logic [CW-1:0] GAP_LEN   = CW'(GAP_CYCLES);

    state_e                  state_q, state_d;
    logic [PROD_W-1:0]       product_q, product_d;
    logic [QTY_W-1:0]        quantity_q, quantity_d;
    logic [PRICE_W-1:0]      unit_price_q, unit_price_d;
    logic [AMOUNT_W-1:0]     paid_q, paid_d;
    logic [QTY_W-1:0]        items_q, items_d;
    logic [AMOUNT_W-1:0]     remain_q, remain_d;
    coin_e                   coin_q, coin_d;
    logic                    refused_q, refused_d;
    logic [AMOUNT_W-1:0]     change_out_q, change_out_d;
    logic [NUM_PRODUCTS-1:0] motor_q, motor_d;
    logic                    coin_10_q, coin_10_d;
    logic                    coin_5_q, coin_5_d;
    logic                    coin_1_q, coin_1_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic [TOTAL_W-1:0]      total_calc;
    logic                    refuse_calc;
    logic [QTY_W-1:0]        items_calc;
    logic [AMOUNT_W-1:0]     change_calc;

    logic                    timer_start;
    logic [CW-1:0]           timer_high_len;
    logic                    pulse_done;
    logic                    gap_done;

    // Transaction arithmetic on the registered request. The total is kept at
    // full 12-bit width so an overflowing order is refused, never wrapped.
    // When accepted, change = paid - total is guaranteed to fit in 8 bits.
    always_comb begin
        total_calc  = TOTAL_W'(unit_price_q) * TOTAL_W'(quantity_q);
        refuse_calc = (product_q < PRODUCT_MIN) || (product_q > PRODUCT_MAX) ||
                      (total_calc > TOTAL_W'(paid_q));
        items_calc  = '0;
        change_calc = paid_q;
        if (!refuse_calc && (quantity_q != '0)) begin
            items_calc  = quantity_q;
            change_calc = paid_q - total_calc[AMOUNT_W-1:0];
        end
    end

    // Next-state logic. Items and coins are consumed when their pulse starts,
    // so at the end of each gap items_q/remain_q say what is still owed.
    // All output flops are loaded from the next state so each output changes
    // on the same edge as the state that owns it.
    always_comb begin
        state_d      = state_q;
        product_d    = product_q;
        quantity_d   = quantity_q;
        unit_price_d = unit_price_q;
        paid_d       = paid_q;
        items_d      = items_q;
        remain_d     = remain_q;
        coin_d       = coin_q;
        refused_d    = refused_q;
        change_out_d = change_out_q;

        case (state_q)
            IDLE: begin
                if (vend_valid) begin
                    product_d    = product;
                    quantity_d   = quantity;
                    unit_price_d = unit_price;
                    paid_d       = paid;
                    state_d      = CALC;
                end
            end
            CALC: begin
                refused_d    = refuse_calc;
                change_out_d = change_calc;
                remain_d     = change_calc;
                items_d      = '0;
                if (items_calc != '0) begin
                    state_d = DISPENSE;
                    items_d = items_calc - QTY_W'(1);
                end else if (change_calc != '0) begin
                    state_d  = CHANGE;
                    coin_d   = pick_coin(change_calc);
                    remain_d = change_calc - coin_value(coin_d);
                end else begin
                    state_d = DONE;
                end
            end
            DISPENSE: begin
                if (pulse_done) begin
                    state_d = D_GAP;
                end
            end
            D_GAP: begin
                if (gap_done) begin
                    if (items_q != '0) begin
                        state_d = DISPENSE;
                        items_d = items_q - QTY_W'(1);
                    end else if (remain_q != '0) begin
                        state_d  = CHANGE;
                        coin_d   = pick_coin(remain_q);
                        remain_d = remain_q - coin_value(coin_d);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CHANGE: begin
                if (pulse_done) begin
                    state_d = C_GAP;
                end
            end
            C_GAP: begin
                if (gap_done) begin
                    if (remain_q != '0) begin
                        state_d  = CHANGE;
                        coin_d   = pick_coin(remain_q);
                        remain_d = remain_q - coin_value(coin_d);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d != IDLE);
        motor_d   = (state_d == DISPENSE)
                    ? (NUM_PRODUCTS'(1) << (product_d - PRODUCT_MIN))
                    : '0;
        coin_10_d = (state_d == CHANGE) && (coin_d == COIN_10);
        coin_5_d  = (state_d == CHANGE) && (coin_d == COIN_5);
        coin_1_d  = (state_d == CHANGE) && (coin_d == COIN_1);
        done_d    = (state_d == DONE);
        error_d   = (state_d == DONE) && refused_d;

        // A fresh pulse begins only when entering a pulse state; staying in
        // DISPENSE/CHANGE lets the running pulse finish.
        timer_start    = (state_d != state_q) &&
                         ((state_d == DISPENSE) || (state_d == CHANGE));
        timer_high_len = (state_d == CHANGE) ? COIN_LEN : MOTOR_LEN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            product_q    <= '0;
            quantity_q   <= '0;
            unit_price_q <= '0;
            paid_q       <= '0;
            items_q      <= '0;
            remain_q     <= '0;
            coin_q       <= COIN_NONE;
            refused_q    <= 1'b0;
            change_out_q <= '0;
            motor_q      <= '0;
            coin_10_q    <= 1'b0;
            coin_5_q     <= 1'b0;
            coin_1_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            product_q    <= product_d;
            quantity_q   <= quantity_d;
            unit_price_q <= unit_price_d;
            paid_q       <= paid_d;
            items_q      <= items_d;
            remain_q     <= remain_d;
            coin_q       <= coin_d;
            refused_q    <= refused_d;
            change_out_q <= change_out_d;
            motor_q      <= motor_d;
            coin_10_q    <= coin_10_d;
            coin_5_q     <= coin_5_d;
            coin_1_q     <= coin_1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    pulse_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (timer_start),
        .high_len   (timer_high_len),
        .low_len    (GAP_LEN),
        .pulse_done (pulse_done),
        .gap_done   (gap_done)
    );

    assign vend_ready = (state_q == IDLE);
    assign motor      = motor_q;
    assign coin_10    = coin_10_q;
    assign coin_5     = coin_5_q;
    assign coin_1     = coin_1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign change_out = change_out_q;

endmodule
